// File: rtl/sd_online_residue_accumulator_if.sv
// rtl/sd_online_residue_accumulator_if.sv - operand/result bundle for the SD residue accumulator
// Optional result_tc signal present when SD_TC_OUTPUT_EN is defined.
interface sd_online_residue_accumulator_if #(
  parameter int BITS  = 4,
  parameter int DELAY = 5
);
  localparam int N = BITS + DELAY;

  logic            start;
  logic            in_valid;
  logic            in_ready;
  logic            mode;
  logic [BITS-1:0] x_plus;
  logic [BITS-1:0] x_minus;
  logic [BITS-1:0] y_plus;
  logic [BITS-1:0] y_minus;
  logic [1:0]      cin_x;
  logic [1:0]      cin_y;
  logic            out_valid;
  logic            out_ready;
  logic [N-1:0]    results_plus;
  logic [N-1:0]    results_minus;
  logic [1:0]      cout;
  logic            overflow;
`ifdef SD_TC_OUTPUT_EN
  logic [N:0]      result_tc;

  modport master (
    output start, in_valid, mode, x_plus, x_minus, y_plus, y_minus, cin_x, cin_y, out_ready,
    input  in_ready, out_valid, results_plus, results_minus, cout, overflow, result_tc
  );
  modport slave (
    input  start, in_valid, mode, x_plus, x_minus, y_plus, y_minus, cin_x, cin_y, out_ready,
    output in_ready, out_valid, results_plus, results_minus, cout, overflow, result_tc
  );
`else
  modport master (
    output start, in_valid, mode, x_plus, x_minus, y_plus, y_minus, cin_x, cin_y, out_ready,
    input  in_ready, out_valid, results_plus, results_minus, cout, overflow
  );
  modport slave (
    input  start, in_valid, mode, x_plus, x_minus, y_plus, y_minus, cin_x, cin_y, out_ready,
    output in_ready, out_valid, results_plus, results_minus, cout, overflow
  );
`endif
endinterface

// File: rtl/sd_online_residue_accumulator.sv
// rtl/sd_online_residue_accumulator.sv - registered signed-digit residue accumulator with frame output
// SD_TC_OUTPUT_EN adds a registered two's-complement result stage (latency 2 instead of 1).
module sd_online_residue_accumulator #(
  parameter int BITS   = 4,
  parameter int DELAY  = 5,
  parameter int DIGITS = 8,
  localparam int N  = BITS + DELAY,
  localparam int CW = $clog2(DIGITS + 1)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  sd_online_residue_accumulator_if.slave bus,
  output logic [CW-1:0]                  digit_cnt_o
);
  // Three guard bits cover base (< 2^N) plus two operands and two carry digits.
  localparam int W = N + 3;

  logic [N-1:0]        r_plus_q, r_minus_q;
  logic [CW-1:0]       cnt_q;
  logic                ovf_q;
  logic                v1_q;
  logic [N-1:0]        res_plus_q, res_minus_q;
  logic [1:0]          cout_q;
  logic                ovf_out_q;

  logic                in_rdy, accept, v1_take;
  logic                fresh, drop, neg, big, last;
  logic signed [W-1:0] base_s, sum_s;
  logic [W-1:0]        mag;
  logic [N-1:0]        nxt_plus, nxt_minus;
  logic [1:0]          nxt_cout;
  logic                nxt_ovf;
  logic [CW-1:0]       nxt_cnt;

  function automatic logic signed [W-1:0] ext(input logic [BITS-1:0] v);
    return $signed({{(W-BITS){1'b0}}, v});
  endfunction

  function automatic logic signed [W-1:0] dig(input logic [1:0] c);
    return $signed(W'(c[1])) - $signed(W'(c[0]));
  endfunction

  assign accept      = bus.in_valid && in_rdy;
  assign bus.in_ready = in_rdy;
  assign digit_cnt_o = cnt_q;

  // Exact-value sum of base, operands and carries, re-encoded as a one-sided SD residue plus carry digit.
  always_comb begin
    fresh     = (cnt_q == '0) || bus.start;
    drop      = 1'b0;
    base_s    = '0;
    if (!fresh) begin
      if (bus.mode) begin
        base_s = $signed({3'b000, r_plus_q[N-2:0], 1'b0}) - $signed({3'b000, r_minus_q[N-2:0], 1'b0});
        drop   = r_plus_q[N-1] ^ r_minus_q[N-1];
      end else begin
        base_s = $signed({3'b000, r_plus_q}) - $signed({3'b000, r_minus_q});
      end
    end
    sum_s     = base_s + ext(bus.x_plus) - ext(bus.x_minus) + ext(bus.y_plus) - ext(bus.y_minus)
              + dig(bus.cin_x) + dig(bus.cin_y);
    neg       = sum_s[W-1];
    mag       = neg ? unsigned'(-sum_s) : unsigned'(sum_s);
    big       = |mag[W-1:N];
    nxt_plus  = neg ? '0 : mag[N-1:0];
    nxt_minus = neg ? mag[N-1:0] : '0;
    nxt_cout  = !big ? 2'b00 : (neg ? 2'b01 : 2'b10);
    nxt_ovf   = (!fresh && ovf_q) || drop || big;
    nxt_cnt   = fresh ? CW'(1) : cnt_q + CW'(1);
    last      = (nxt_cnt == CW'(DIGITS));
  end

  // Residue, operand count and running overflow advance only on accepted operands.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_plus_q  <= '0;
      r_minus_q <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
    end else if (accept) begin
      r_plus_q  <= nxt_plus;
      r_minus_q <= nxt_minus;
      if (last) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        cnt_q <= nxt_cnt;
        ovf_q <= nxt_ovf;
      end
    end
  end

  // First output stage: captures the frame result on the frame-ending accept, holds until taken.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v1_q        <= 1'b0;
      res_plus_q  <= '0;
      res_minus_q <= '0;
      cout_q      <= 2'b00;
      ovf_out_q   <= 1'b0;
    end else begin
      if (v1_take) v1_q <= 1'b0;
      if (accept && last) begin
        v1_q        <= 1'b1;
        res_plus_q  <= nxt_plus;
        res_minus_q <= nxt_minus;
        cout_q      <= nxt_cout;
        ovf_out_q   <= nxt_ovf;
      end
    end
  end

`ifdef SD_TC_OUTPUT_EN
  logic         v2_q;
  logic [N-1:0] res2_plus_q, res2_minus_q;
  logic [1:0]   cout2_q;
  logic         ovf2_q;
  logic [N:0]   tc_q;

  assign in_rdy  = !(v2_q && !bus.out_ready);
  assign v1_take = v1_q && (!v2_q || bus.out_ready);

  // Second output stage: adds the two's-complement view, moves only when empty or draining.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v2_q         <= 1'b0;
      res2_plus_q  <= '0;
      res2_minus_q <= '0;
      cout2_q      <= 2'b00;
      ovf2_q       <= 1'b0;
      tc_q         <= '0;
    end else begin
      if (v2_q && bus.out_ready) v2_q <= 1'b0;
      if (v1_take) begin
        v2_q         <= 1'b1;
        res2_plus_q  <= res_plus_q;
        res2_minus_q <= res_minus_q;
        cout2_q      <= cout_q;
        ovf2_q       <= ovf_out_q;
        tc_q         <= {1'b0, res_plus_q} - {1'b0, res_minus_q};
      end
    end
  end

  assign bus.out_valid     = v2_q;
  assign bus.results_plus  = res2_plus_q;
  assign bus.results_minus = res2_minus_q;
  assign bus.cout          = cout2_q;
  assign bus.overflow      = ovf2_q;
  assign bus.result_tc     = tc_q;
`else
  assign in_rdy  = !(v1_q && !bus.out_ready);
  assign v1_take = v1_q && bus.out_ready;

  assign bus.out_valid     = v1_q;
  assign bus.results_plus  = res_plus_q;
  assign bus.results_minus = res_minus_q;
  assign bus.cout          = cout_q;
  assign bus.overflow      = ovf_out_q;
`endif
endmodule

// File: tb/tb_sd_online_residue_accumulator.sv
// tb/tb_sd_online_residue_accumulator.sv - scoreboard bench for sd_online_residue_accumulator
module tb_sd_online_residue_accumulator;
  localparam int BITS = 4, DELAY = 5, DIGITS = 8, N = BITS + DELAY, CW = $clog2(DIGITS + 1);

  typedef struct {
    int val;
    int co;
    int ovf;
    bit chk_val;
  } exp_t;

  logic          clk;
  logic          reset_n;
  logic [CW-1:0] digit_cnt;
  exp_t          sb_q[$];
  exp_t          mon_e;
  int            n_checks, n_fail, n_pushed, n_seen;

  sd_online_residue_accumulator_if #(.BITS(BITS), .DELAY(DELAY)) bif ();

  sd_online_residue_accumulator #(.BITS(BITS), .DELAY(DELAY), .DIGITS(DIGITS)) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bif.slave),
    .digit_cnt_o(digit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic push_exp(input int v, input int co, input int ovf, input bit cv);
    exp_t e;
    e.val = v; e.co = co; e.ovf = ovf; e.chk_val = cv;
    sb_q.push_back(e);
    n_pushed++;
  endtask

  task automatic send(input logic st, input logic md, input logic [3:0] xp, input logic [3:0] xm,
                      input logic [3:0] yp, input logic [3:0] ym, input logic [1:0] cx, input logic [1:0] cy);
    bit done;
    int waited;
    done = 0;
    waited = 0;
    bif.start = st; bif.mode = md;
    bif.x_plus = xp; bif.x_minus = xm; bif.y_plus = yp; bif.y_minus = ym;
    bif.cin_x = cx; bif.cin_y = cy;
    bif.in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (bif.in_ready) begin
        done = 1;
      end else if (waited++ > 100) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: got in_ready 0 for %0d cycles, expected 1", waited);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    bif.in_valid = 1'b0;
    bif.start = 1'b0;
  endtask

  task automatic send_zeros(input int n, input logic md);
    for (int i = 0; i < n; i++) send(1'b0, md, 4'd0, 4'd0, 4'd0, 4'd0, 2'b00, 2'b00);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_out_valid"}, int'(bif.out_valid), 0);
    check({tag, "_digit_cnt"}, int'(digit_cnt), 0);
    check({tag, "_results_plus"}, int'(bif.results_plus), 0);
    check({tag, "_results_minus"}, int'(bif.results_minus), 0);
    check({tag, "_cout"}, int'(bif.cout), 0);
    check({tag, "_overflow"}, int'(bif.overflow), 0);
    check({tag, "_in_ready"}, int'(bif.in_ready), 1);
  endtask

  // Monitor: every output handshake pops one expected frame result.
  always @(negedge clk) begin
    if (reset_n && bif.out_valid && bif.out_ready) begin
      n_seen++;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got value %0d, expected no output",
                 int'(bif.results_plus) - int'(bif.results_minus));
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e.chk_val) begin
          check("result_value", int'(bif.results_plus) - int'(bif.results_minus), mon_e.val);
          check("result_cout", int'(bif.cout[1]) - int'(bif.cout[0]), mon_e.co);
        end
        check("result_overflow", int'(bif.overflow), mon_e.ovf);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test by time limit, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0; n_fail = 0; n_pushed = 0; n_seen = 0;
    bif.start = 0; bif.in_valid = 0; bif.mode = 0; bif.out_ready = 1;
    bif.x_plus = 0; bif.x_minus = 0; bif.y_plus = 0; bif.y_minus = 0;
    bif.cin_x = 0; bif.cin_y = 0;
    reset_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_cleared("reset");
    @(posedge clk); #1;
    reset_n = 1;

    // Mode 0: +5 -3, then +1 with carry +1, padding zeros -> 4
    send(1'b1, 1'b0, 4'd5, 4'd0, 4'd0, 4'd3, 2'b00, 2'b00);
    check("cnt_after_op1", int'(digit_cnt), 1);
    send(1'b0, 1'b0, 4'd1, 4'd0, 4'd0, 4'd0, 2'b10, 2'b00);
    check("cnt_after_op2", int'(digit_cnt), 2);
    send_zeros(5, 1'b0);
    push_exp(4, 0, 0, 1);
    send_zeros(1, 1'b0);
`ifdef SD_TC_OUTPUT_EN
    @(posedge clk); #1;
`endif
    @(negedge clk);
    check("latency_out_valid", int'(bif.out_valid), 1);
    check("frame_end_digit_cnt", int'(digit_cnt), 0);

    // Mode 1: zeros, then +3 (plus 0111, minus 0100), then +1 -> 7
    send(1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 2'b00, 2'b00);
    send_zeros(5, 1'b1);
    send(1'b0, 1'b1, 4'd7, 4'd4, 4'd0, 4'd0, 2'b00, 2'b00);
    push_exp(7, 0, 0, 1);
    send(1'b0, 1'b1, 4'd1, 4'd0, 4'd0, 4'd0, 2'b00, 2'b00);
    check("mode1_digit_cnt", int'(digit_cnt), 0);

    // Mode 0 negative: -31 then seven times -32 -> -255
    send(1'b1, 1'b0, 4'd0, 4'd15, 4'd0, 4'd15, 2'b11, 2'b01);
    for (int i = 0; i < 6; i++) send(1'b0, 1'b0, 4'd0, 4'd15, 4'd0, 4'd15, 2'b01, 2'b01);
    push_exp(-255, 0, 0, 1);
    send(1'b0, 1'b0, 4'd0, 4'd15, 4'd0, 4'd15, 2'b01, 2'b01);

    // Back-pressure: frame of eight +1 held for 5 cycles, pending start operand +2
    for (int i = 0; i < 7; i++) send(i == 0, 1'b0, 4'd1, 4'd0, 4'd0, 4'd0, 2'b00, 2'b00);
    bif.out_ready = 0;
    push_exp(8, 0, 0, 1);
    send(1'b0, 1'b0, 4'd1, 4'd0, 4'd0, 4'd0, 2'b00, 2'b00);
`ifdef SD_TC_OUTPUT_EN
    @(posedge clk); #1;
`endif
    bif.start = 1; bif.mode = 0; bif.x_plus = 4'd2; bif.x_minus = 0;
    bif.y_plus = 0; bif.y_minus = 0; bif.cin_x = 0; bif.cin_y = 0;
    bif.in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_out_valid", int'(bif.out_valid), 1);
      check("stall_in_ready", int'(bif.in_ready), 0);
      check("stall_digit_cnt", int'(digit_cnt), 0);
      @(posedge clk); #1;
    end
    bif.out_ready = 1;
    @(negedge clk);
    check("release_in_ready", int'(bif.in_ready), 1);
    @(posedge clk); #1;
    bif.in_valid = 0; bif.start = 0;
    check("release_digit_cnt", int'(digit_cnt), 1);
    check("release_out_valid", int'(bif.out_valid), 0);
    for (int i = 0; i < 6; i++) send(1'b0, 1'b0, 4'd1, 4'd0, 4'd0, 4'd0, 2'b00, 2'b00);
    push_exp(9, 0, 0, 1);
    send(1'b0, 1'b0, 4'd1, 4'd0, 4'd0, 4'd0, 2'b00, 2'b00);

    // Mode 1 with +15 every operand: leaves the 9-digit range
    send(1'b1, 1'b1, 4'd15, 4'd0, 4'd0, 4'd0, 2'b00, 2'b00);
    for (int i = 0; i < 6; i++) send(1'b0, 1'b1, 4'd15, 4'd0, 4'd0, 4'd0, 2'b00, 2'b00);
    push_exp(0, 0, 1, 0);
    send(1'b0, 1'b1, 4'd15, 4'd0, 4'd0, 4'd0, 2'b00, 2'b00);

    // Carry-out: accumulate 127, 2*127+1 = 255, then 2*255+32 = 542 = 30 + 512
    send(1'b1, 1'b0, 4'd15, 4'd0, 4'd15, 4'd0, 2'b10, 2'b11);
    for (int i = 0; i < 3; i++) send(1'b0, 1'b0, 4'd15, 4'd0, 4'd15, 4'd0, 2'b10, 2'b10);
    send_zeros(2, 1'b0);
    send(1'b0, 1'b1, 4'd1, 4'd0, 4'd0, 4'd0, 2'b00, 2'b00);
    push_exp(30, 1, 1, 1);
    send(1'b0, 1'b1, 4'd15, 4'd0, 4'd15, 4'd0, 2'b10, 2'b10);

    // Zero frame after overflow: flag cleared
    send(1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 2'b00, 2'b00);
    send_zeros(6, 1'b1);
    push_exp(0, 0, 0, 1);
    send_zeros(1, 1'b1);

    // Start mid-frame: +7, +7, start +2, seven zeros -> single output 2
    send(1'b1, 1'b0, 4'd7, 4'd0, 4'd0, 4'd0, 2'b00, 2'b00);
    send(1'b0, 1'b0, 4'd7, 4'd0, 4'd0, 4'd0, 2'b00, 2'b00);
    send(1'b1, 1'b0, 4'd2, 4'd0, 4'd0, 4'd0, 2'b00, 2'b00);
    check("restart_digit_cnt", int'(digit_cnt), 1);
    send_zeros(6, 1'b0);
    push_exp(2, 0, 0, 1);
    send_zeros(1, 1'b0);

    // Reset after 3 operands, then eight +1 -> 8
    for (int i = 0; i < 3; i++) send(i == 0, 1'b0, 4'd1, 4'd0, 4'd0, 4'd0, 2'b00, 2'b00);
    reset_n = 0;
    @(posedge clk); #1;
    reset_n = 1;
    check_cleared("midreset");
    for (int i = 0; i < 7; i++) send(1'b0, 1'b0, 4'd1, 4'd0, 4'd0, 4'd0, 2'b00, 2'b00);
    push_exp(8, 0, 0, 1);
    send(1'b0, 1'b0, 4'd1, 4'd0, 4'd0, 4'd0, 2'b00, 2'b00);

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    check("outputs_seen", n_seen, n_pushed);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
